// File: rtl/one_hot_pkg.sv
// Shared types and helpers for the one-hot ring counter monitor.
// Optional err_count output is enabled by defining ONE_HOT_MON_ERRCNT_EN.
package one_hot_pkg;

   localparam int ONE_HOT_WIDTH = 8;
   // Helpers operate on a fixed-size carrier; the active width is passed in (must be < 64).
   localparam int ONE_HOT_MAX_W = 64;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SYNC     = 2'd1,
      LOCKED   = 2'd2
   } mon_state_t;

   function automatic logic [ONE_HOT_MAX_W-1:0] rotl(input logic [ONE_HOT_MAX_W-1:0] v,
                                                     input int w);
      logic [ONE_HOT_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ONE_HOT_MAX_W; i++) begin
         if (i < w) r[(i + 1) % w] = v[i];
      end
      return r;
   endfunction

   function automatic logic is_one_hot(input logic [ONE_HOT_MAX_W-1:0] v, input int w);
      int cnt;
      cnt = 0;
      for (int i = 0; i < ONE_HOT_MAX_W; i++) begin
         if (i < w && v[i]) cnt++;
      end
      return (cnt == 1);
   endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary index decoder with a legal (exactly-one-bit) flag.
// Index is only meaningful when legal is high.
module onehot_to_bin
   import one_hot_pkg::*;
#(
   parameter int WIDTH = ONE_HOT_WIDTH,
   localparam int IW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [IW-1:0]    index,
   output logic             legal
);

   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) index = index | IW'(i);
      end
      legal = is_one_hot(ONE_HOT_MAX_W'(onehot), WIDTH);
   end

endmodule

// File: rtl/one_hot_monitor.sv
// Receive-side checker for a left-rotating one-hot ring counter stream.
// Define ONE_HOT_MON_ERRCNT_EN to add the saturating err_count output.
//
// state    | meaning
// UNLOCKED | no legal sample seen yet, or sequence lost
// SYNC     | collecting consecutive in-sequence samples
// LOCKED   | tracking rotation; breaks pulse err, wraps count laps
module one_hot_monitor
   import one_hot_pkg::*;
#(
   parameter int WIDTH    = ONE_HOT_WIDTH,
   parameter int LAP_W    = 16,
   parameter int RESYNC_N = 2,
   localparam int IW      = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] in_onehot,
   output logic [IW-1:0]    index,
   output logic             valid,
   output logic             locked,
   output logic             err,
   output logic [LAP_W-1:0] lap_count
`ifdef ONE_HOT_MON_ERRCNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   localparam int SW = $clog2(RESYNC_N + 1);

   mon_state_t                        state, state_nxt;
   logic [SW-1:0]                     sync_cnt, sync_nxt;
   logic [WIDTH-1:0]                  expected, expected_nxt;
   logic [IW-1:0]                     dec_index;
   logic                              dec_legal;
   logic [WIDTH-1:0]                  rot_in;
   logic [ONE_HOT_MAX_W-WIDTH-1:0]    rot_unused;
   logic                              in_seq;
   logic                              err_nxt;
   logic                              lap_inc;

   onehot_to_bin #(.WIDTH(WIDTH)) u_dec (
      .onehot (in_onehot),
      .index  (dec_index),
      .legal  (dec_legal)
   );

   assign {rot_unused, rot_in} = rotl(ONE_HOT_MAX_W'(in_onehot), WIDTH);
   assign in_seq               = (in_onehot == expected);
   assign locked               = (state == LOCKED);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= UNLOCKED;
         sync_cnt <= '0;
         expected <= '0;
      end else begin
         state    <= state_nxt;
         sync_cnt <= sync_nxt;
         expected <= expected_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      sync_nxt     = sync_cnt;
      expected_nxt = expected;
      if (enable) begin
         case (state)
            UNLOCKED: begin
               if (dec_legal) begin
                  sync_nxt     = SW'(1);
                  expected_nxt = rot_in;
                  state_nxt    = (RESYNC_N <= 1) ? LOCKED : SYNC;
               end
            end
            SYNC: begin
               if (!dec_legal) begin
                  sync_nxt  = '0;
                  state_nxt = UNLOCKED;
               end else if (in_seq) begin
                  sync_nxt     = sync_cnt + SW'(1);
                  expected_nxt = rot_in;
                  if (int'(sync_cnt) + 1 >= RESYNC_N) state_nxt = LOCKED;
               end else begin
                  // Legal but out of order: restart the run from this sample.
                  sync_nxt     = SW'(1);
                  expected_nxt = rot_in;
               end
            end
            LOCKED: begin
               if (in_seq) begin
                  expected_nxt = rot_in;
               end else begin
                  sync_nxt  = '0;
                  state_nxt = UNLOCKED;
               end
            end
            default: state_nxt = UNLOCKED;
         endcase
      end
   end

   always_comb begin
      err_nxt = enable && (state == LOCKED) && !in_seq;
      lap_inc = enable && (state == LOCKED) && in_seq && (in_onehot == WIDTH'(1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         index     <= '0;
         valid     <= 1'b0;
         err       <= 1'b0;
         lap_count <= '0;
      end else begin
         err <= err_nxt;
         if (enable) begin
            valid <= dec_legal;
            if (dec_legal) index <= dec_index;
         end
         if (lap_inc) lap_count <= lap_count + LAP_W'(1);
      end
   end

`ifdef ONE_HOT_MON_ERRCNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_count <= '0;
      end else if (err_nxt && err_count != 8'hFF) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/one_hot_monitor.md
# one_hot_monitor

Receive-side checker for the 8-bit one-hot ring counter stream. Samples the counter's output each enabled clock and decodes the active bit to a binary index. Locks onto the legal rotation sequence, counts completed laps and flags any out-of-sequence or non-one-hot pattern. Sits directly downstream of the counter, on the same clock, reset and enable, for use both as a design block and as the bench's self-check.

## Interface
- WIDTH, 8, one-hot vector width (≥2)
- LAP_W, 16, lap counter width
- RESYNC_N, 2, consecutive in-sequence samples required to lock (≥1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  sample qualifier, shared with the counter; low = hold
- in_onehot  in  WIDTH  counter output being monitored
- index  out  $clog2(WIDTH)  binary position of the last legal sample
- valid  out  1  last sample had exactly one bit set
- locked  out  1  monitor is tracking the rotation
- err  out  1  one-cycle pulse on a sequence break while locked
- lap_count  out  LAP_W  completed laps while locked
- err_count  out  8  saturating error count (ONE_HOT_MON_ERRCNT_EN only)

## Operation
- Stream format: left rotation, 0x01→0x02→…→0x80→0x01; counter resets to 0x01.
- Legal sample: exactly one bit set. expected = rotl(last legal sample).
- States: UNLOCKED, SYNC, LOCKED; reset → UNLOCKED, sync_cnt 0, expected 0.
- UNLOCKED: legal → SYNC, sync_cnt=1, expected=rotl(in); illegal → stay.
- SYNC: in==expected → sync_cnt+1, expected rotates; sync_cnt reaching RESYNC_N → LOCKED. Legal mismatch → stay in SYNC, sync_cnt=1, restart from in. Illegal → UNLOCKED. No err in SYNC.
- LOCKED: in==expected → stay, expected rotates; in==0x01 (wrap from MSB) → lap_count+1, wraps mod 2^LAP_W. Any mismatch (legal or not) → err=1 for one cycle, → UNLOCKED.
- RESYNC_N=1: first legal sample locks directly from UNLOCKED.
- valid/index update on every enabled sample regardless of state; illegal sample → valid=0, index holds.
- enable low: no sampling; state, expected, index, valid, locked, counters hold; err=0.
- lap_count holds across unlock; cleared only by reset.

## Timing
- All outputs registered; reset value 0 for every output.
- Sample taken at rising edge with enable=1; results visible after that edge (latency 1 from input set-up).
- With RESYNC_N=2: locked rises after the edge sampling the 2nd consecutive in-sequence value.
- err asserts after the edge sampling the bad value, deasserts next edge; locked falls on the same edge err rises.
- Lap increments after the edge sampling 0x01 while LOCKED.
- Reset asserted mid-operation: outputs 0 asynchronously; first enabled sample after release treated as from UNLOCKED.

## Configuration
- ONE_HOT_MON_ERRCNT_EN defined: err_count present; +1 on every err pulse, saturates at 255; reset 0.
- Undefined: err_count port and its register removed; all other behaviour identical.

## Structure
- Package one_hot_pkg: WIDTH default constant, state enum (UNLOCKED, SYNC, LOCKED), rotl function, popcount-is-one function.
- Sub-module onehot_to_bin: combinational WIDTH-bit one-hot → index plus legal flag; instantiated once.

## Test plan
- Reset 40 ns, then enable=1 driving 0x01,0x02,0x04… → locked=1 after the 0x02 sample, index tracks 0,1,2…, err=0.
- Run 3 full rotations locked → lap_count=3 after the third 0x80→0x01 transition (only wraps while locked count).
- While locked at 0x08, force 0x20 → err pulse 1 cycle, locked=0, err_count=1 with macro; resume 0x40,0x80 → relock after 0x80.
- Inject 0x00 and 0x03 → valid=0, index holds, err only if locked, state UNLOCKED.
- enable=0 for 5 cycles mid-rotation with input frozen → all outputs unchanged, no err.
- Assert reset while locked with lap_count=2 → all outputs 0 immediately, before next clock edge.
